// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer between MEM and dmem.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;   // default number of queued stores
    localparam int WORD_OFS = 2;   // byte-offset bits below the word address
    localparam int SB_AW    = 32;  // address width carried in an entry
    localparam int SB_DW    = 32;  // data width carried in an entry

    // One posted store: byte address, data already lane-aligned, byte/word flag.
    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
        logic             byte_en;
    } sb_entry_t;

endpackage : store_buffer_pkg

// File: rtl/sb_match.sv
// Youngest-match search over the queued stores for load forwarding.
// Ages are counted back from wr_ptr, so age 0 is the most recently pushed
// entry; the lowest matching age wins.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  sb_entry_t                    entries [DEPTH],
    input  logic [DEPTH-1:0]             valid,
    input  logic [$clog2(DEPTH)-1:0]     wr_ptr,
    input  logic [AW-1:0]                ld_addr,
    output logic                         hit,
    output logic                         is_byte,
    output logic [DW-1:0]                data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    age_idx [DEPTH];
    logic [DEPTH-1:0] age_match;
    logic [DEPTH-1:0] unused_addr_lsb;
    logic             unused_ok;

    // Map each age to its slot and flag word-address matches on valid slots.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign age_idx[gi]   = wr_ptr - PW'(gi + 1);
        assign age_match[gi] = valid[age_idx[gi]] &&
            (entries[age_idx[gi]].addr[AW-1:WORD_OFS] == ld_addr[AW-1:WORD_OFS]);
        assign unused_addr_lsb[gi] = ^entries[gi].addr[WORD_OFS-1:0];
    end

    // Byte offsets never take part in the word-granular compare.
    assign unused_ok = ^{unused_addr_lsb, ld_addr[WORD_OFS-1:0]};

    // Priority select: walk from oldest to youngest so the youngest match is the last write.
    always_comb begin
        hit     = 1'b0;
        is_byte = 1'b0;
        data    = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (age_match[k]) begin
                hit     = 1'b1;
                is_byte = entries[age_idx[k]].byte_en;
                data    = entries[age_idx[k]].data;
            end
        end
    end

endmodule : sb_match

// File: rtl/store_buffer.sv
// Posted-write FIFO between the MEM stage and data memory. Stores are queued
// and drained in order, one per cycle, onto the dmem write port; younger loads
// get full-word forwarding or a stall on a byte-store overlap.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                     clk,
    input  logic                     reset,
    // store side (MEM stage)
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic                     st_byte,
    output logic                     st_ready,
    // load forwarding
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hit,
    output logic [DW-1:0]            ld_data,
    output logic                     ld_stall,
    // dmem write port
    input  logic                     mem_ready,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_a,
    output logic [DW-1:0]            mem_wd,
    output logic                     mem_b,
    // status
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        entries_reg [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    logic             push;
    logic             drain;
    logic [DEPTH-1:0] valid;
    logic             m_hit;
    logic             m_is_byte;
    logic [DW-1:0]    m_data;

    // Handshakes depend only on registered occupancy, so a full buffer stays
    // closed even in a cycle where the head drains.
    assign empty    = (count_reg == '0);
    assign st_ready = (count_reg < CW'(DEPTH));
    assign count    = count_reg;
    assign push     = st_valid && st_ready;
    assign drain    = !empty && mem_ready;

    // Head entry drives the dmem port directly; it sits unchanged while empty.
    assign mem_we = !empty;
    assign mem_a  = entries_reg[rd_ptr_reg].addr;
    assign mem_wd = entries_reg[rd_ptr_reg].data;
    assign mem_b  = entries_reg[rd_ptr_reg].byte_en;

    // A slot is live when its distance from the head is below the occupancy.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        logic [PW-1:0] ofs;
        assign ofs       = PW'(gi) - rd_ptr_reg;
        assign valid[gi] = (CW'(ofs) < count_reg);
    end

    // Entry payload: written on accepted push; stale slots are masked by valid.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_reg[wr_ptr_reg] <= '{addr: st_addr, data: st_data, byte_en: st_byte};
        end
    end

    // FIFO control: pointers wrap naturally, count moves only on push xor drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (drain) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, drain})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match (
        .entries (entries_reg),
        .valid   (valid),
        .wr_ptr  (wr_ptr_reg),
        .ld_addr (ld_addr),
        .hit     (m_hit),
        .is_byte (m_is_byte),
        .data    (m_data)
    );

    // Forwarding outputs are quiet unless a load is actually present.
    assign ld_hit   = ld_valid && m_hit && !m_is_byte;
    assign ld_stall = ld_valid && m_hit && m_is_byte;
    assign ld_data  = ld_hit ? m_data : '0;

endmodule : store_buffer

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_byte;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        ld_stall;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_b;
    logic        empty;
    logic [2:0]  count;

    store_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_byte   (st_byte),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .ld_data   (ld_data),
        .ld_stall  (ld_stall),
        .mem_ready (mem_ready),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_b     (mem_b),
        .empty     (empty),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        b;
    } m_entry_t;

    m_entry_t    q[$];        // model: pending stores, oldest first
    logic [31:0] drained[$];  // addresses dmem accepted, in order
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the queue model, then advance the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic        f_hit, f_stall, found;
            logic [31:0] f_data;
            bit          do_push, do_drain;

            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_empty", 32'(empty), 32'(q.size() == 0));
            chk("m_st_ready", 32'(st_ready), 32'(q.size() < 4));
            chk("m_mem_we", 32'(mem_we), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("m_mem_a", mem_a, q[0].addr);
                chk("m_mem_wd", mem_wd, q[0].data);
                chk("m_mem_b", 32'(mem_b), 32'(q[0].b));
            end

            f_hit = 0; f_stall = 0; f_data = '0; found = 0;
            if (ld_valid) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (!found && (q[i].addr >> 2) == (ld_addr >> 2)) begin
                        found = 1;
                        if (q[i].b) f_stall = 1;
                        else begin
                            f_hit  = 1;
                            f_data = q[i].data;
                        end
                    end
                end
            end
            chk("m_ld_hit", 32'(ld_hit), 32'(f_hit));
            chk("m_ld_stall", 32'(ld_stall), 32'(f_stall));
            chk("m_ld_data", ld_data, f_data);

            if (mem_we && mem_ready) drained.push_back(mem_a);

            if (reset) begin
                q.delete();
            end else begin
                do_push  = st_valid && (q.size() < 4);
                do_drain = (q.size() > 0) && mem_ready;
                if (do_drain) void'(q.pop_front());
                if (do_push) q.push_back('{addr: st_addr, data: st_data, b: st_byte});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic b);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_byte  = b;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic drain_all(input int budget);
        mem_ready = 1'b1;
        for (int i = 0; i < budget && !empty; i++) tick();
        chk("drain_timeout", 32'(empty), 32'd1);
        mem_ready = 1'b0;
    endtask

    task automatic chk_drained(input string name, input logic [31:0] exp[$]);
        chk({name, "_len"}, 32'(drained.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < drained.size(); i++)
            chk($sformatf("%s_%0d", name, i), drained[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; st_valid = 0; st_addr = 0; st_data = 0; st_byte = 0;
        ld_valid = 0; ld_addr = 0; mem_ready = 0;
        tick();
        chk_en = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_st_ready", 32'(st_ready), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);

        // Reset while three stores are pending and dmem is not ready.
        push_one(32'h40, 32'h4040_4040, 0);
        push_one(32'h44, 32'h4444_4444, 0);
        push_one(32'h48, 32'h4848_4848, 0);
        chk("pre_rst_count", 32'(count), 32'd3);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        drained.delete();
        mem_ready = 1;
        tick();
        tick();
        chk("mid_rst_writes", 32'(drained.size()), 32'd0);
        mem_ready = 0;

        // Fill to DEPTH, try a fifth store, then drain in order.
        for (int i = 0; i < 4; i++) push_one(32'(i * 4), 32'hA000_0000 + 32'(i), 0);
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_st_ready", 32'(st_ready), 32'd0);
        st_valid = 1; st_addr = 32'h50; st_data = 32'h5555_5555; st_byte = 0;
        tick();
        #1;
        chk("full_ignore_count", 32'(count), 32'd4);
        drained.delete();
        mem_ready = 1;
        tick();             // drain while still full: the held store must stay out
        st_valid = 0;
        tick(); tick(); tick();
        #1;
        chk("fill_empty", 32'(empty), 32'd1);
        chk_drained("fill_order", '{32'h00, 32'h04, 32'h08, 32'h0C});
        mem_ready = 0;

        // Push and drain together at count=2; pointers wrap past DEPTH-1.
        push_one(32'h60, 32'h6000_0060, 0);
        push_one(32'h64, 32'h6000_0064, 0);
        drained.delete();
        mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1; st_addr = 32'h68 + 32'(i * 4); st_data = 32'h6000_0068 + 32'(i * 4); st_byte = 0;
            tick();
            #1;
            chk($sformatf("pd_count_%0d", i), 32'(count), 32'd2);
        end
        st_valid = 0;
        tick(); tick();
        #1;
        chk("pd_empty", 32'(empty), 32'd1);
        chk_drained("pd_order", '{32'h60, 32'h64, 32'h68, 32'h6C, 32'h70});
        mem_ready = 0;

        // Word forwarding: the younger of two matching stores wins.
        push_one(32'h10, 32'h1111_1111, 0);
        push_one(32'h10, 32'h2222_2222, 0);
        ld_valid = 1; ld_addr = 32'h12;
        #1;
        chk("fwd_hit", 32'(ld_hit), 32'd1);
        chk("fwd_data", ld_data, 32'h2222_2222);
        chk("fwd_stall", 32'(ld_stall), 32'd0);
        ld_addr = 32'h14;
        #1;
        chk("fwd_miss_hit", 32'(ld_hit), 32'd0);
        ld_addr = 32'h12; ld_valid = 0;
        #1;
        chk("fwd_novalid_hit", 32'(ld_hit), 32'd0);
        chk("fwd_novalid_data", ld_data, 32'd0);
        tick();
        drain_all(10);

        // Byte overlap: younger byte store over an older word store forces a stall.
        push_one(32'h20, 32'hCAFE_F00D, 0);
        push_one(32'h21, 32'h0000_AB00, 1);
        ld_valid = 1; ld_addr = 32'h20;
        #1;
        chk("byte_stall", 32'(ld_stall), 32'd1);
        chk("byte_hit", 32'(ld_hit), 32'd0);
        mem_ready = 1;
        #1;
        chk("byte_head0_a", mem_a, 32'h20);
        tick();
        #1;
        chk("byte_stall_held", 32'(ld_stall), 32'd1);
        chk("byte_head1_a", mem_a, 32'h21);
        chk("byte_head1_b", 32'(mem_b), 32'd1);
        chk("byte_head1_wd", mem_wd, 32'h0000_AB00);
        tick();
        #1;
        chk("byte_stall_clear", 32'(ld_stall), 32'd0);
        chk("byte_hit_after", 32'(ld_hit), 32'd0);
        mem_ready = 0; ld_valid = 0;

        // A store pushed in the lookup cycle is invisible until the next cycle.
        st_valid = 1; st_addr = 32'h30; st_data = 32'h3333_3333; st_byte = 0;
        ld_valid = 1; ld_addr = 32'h30;
        #1;
        chk("same_cyc_hit", 32'(ld_hit), 32'd0);
        tick();
        st_valid = 0;
        #1;
        chk("next_cyc_hit", 32'(ld_hit), 32'd1);
        chk("next_cyc_data", ld_data, 32'h3333_3333);
        ld_valid = 0;
        drain_all(10);

        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_store_buffer
